// File: rtl/gba_cart_pkg.sv
// gba_cart_pkg
// Shared types and constants for the GBA cartridge ROM reader.
//   burst_state_t  : burst FSM states
//   *_BIT          : bit positions of the control pins within cart_tran_bank0
//   bus_drive_t    : registered pin/status drive produced by the burst FSM
//   drive_for()    : pin drive belonging to each FSM state
//   is_rumble_code : game-code character 0 test for rumble carts
package gba_cart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_HOLD,
    S_TURN,
    S_RD_LOW,
    S_RD_HIGH,
    S_END
  } burst_state_t;

  localparam int CS_N_BIT = 4;
  localparam int RD_N_BIT = 5;
  localparam int WR_N_BIT = 6;

  // Halfword address of header byte 0xAC (game code character 0).
  localparam logic [23:0] GAME_CODE_HW_ADDR = 24'h000056;
  localparam logic [7:0]  RUMBLE_CODE_R     = 8'h52;  // "R"
  localparam logic [7:0]  RUMBLE_CODE_V     = 8'h56;  // "V"

  typedef struct packed {
    logic        cs_n;
    logic        rd_n;
    logic        ad_oe;
    logic [15:0] ad_out;
    logic [7:0]  a_hi;
    logic        busy;
    logic        done;
  } bus_drive_t;

  // Pin state for a given FSM state. The low address is only driven while
  // the cart latches it; A[23:16] stays up for the whole burst.
  function automatic bus_drive_t drive_for(burst_state_t s, logic [23:0] a);
    bus_drive_t d;
    d.cs_n   = 1'b1;
    d.rd_n   = 1'b1;
    d.ad_oe  = 1'b0;
    d.ad_out = 16'h0000;
    d.a_hi   = 8'h00;
    d.busy   = 1'b1;
    d.done   = 1'b0;
    case (s)
      S_IDLE: d.busy = 1'b0;
      S_ADDR_SETUP: begin
        d.ad_oe  = 1'b1;
        d.ad_out = a[15:0];
        d.a_hi   = a[23:16];
      end
      S_ADDR_HOLD: begin
        d.cs_n   = 1'b0;
        d.ad_oe  = 1'b1;
        d.ad_out = a[15:0];
        d.a_hi   = a[23:16];
      end
      S_TURN, S_RD_HIGH: begin
        d.cs_n = 1'b0;
        d.a_hi = a[23:16];
      end
      S_RD_LOW: begin
        d.cs_n = 1'b0;
        d.rd_n = 1'b0;
        d.a_hi = a[23:16];
      end
      S_END: d.done = 1'b1;
      default: d.busy = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic is_rumble_code(logic [7:0] c);
    return (c == RUMBLE_CODE_R) || (c == RUMBLE_CODE_V);
  endfunction

endpackage

// File: rtl/gba_cart_reader_burst.sv
// gba_rom_burst
// Burst FSM for the multiplexed GBA ROM bus: address phase, bus turnaround,
// then len /RD strobes while the cart auto-increments its address.
//   clk_74a, reset : clock, synchronous active-high reset
//   start/addr/len : burst request (accepted only in IDLE)
//   cs_n, rd_n     : bus strobes (registered)
//   ad_oe, ad_out  : AD[15:0] drive enable and value (registered)
//   a_hi           : A[23:16] (registered)
//   busy, done     : status (registered)
//   sample         : high on the last RD_LOW cycle; AD is captured at its end
//
// state        | meaning
// IDLE         | bus parked, waiting for start
// ADDR_SETUP   | address on AD/A, /CS high (T_AS cycles)
// ADDR_HOLD    | /CS low, address held (T_AH cycles)
// TURN         | AD released before the first /RD (T_TURN cycles)
// RD_LOW       | /RD low, cart drives AD (T_RD cycles)
// RD_HIGH      | /RD high between halfwords (T_RDH cycles)
// END          | /CS released, done pulse (1 cycle)
module gba_rom_burst
  import gba_cart_pkg::*;
#(
  parameter int T_AS   = 4,
  parameter int T_AH   = 4,
  parameter int T_TURN = 2,
  parameter int T_RD   = 12,
  parameter int T_RDH  = 4
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        cs_n,
  output logic        rd_n,
  output logic        ad_oe,
  output logic [15:0] ad_out,
  output logic [7:0]  a_hi,
  output logic        busy,
  output logic        done,
  output logic        sample
);

  localparam logic [7:0] AS_LD   = 8'(T_AS - 1);
  localparam logic [7:0] AH_LD   = 8'(T_AH - 1);
  localparam logic [7:0] TURN_LD = 8'(T_TURN - 1);
  localparam logic [7:0] RD_LD   = 8'(T_RD - 1);
  localparam logic [7:0] RDH_LD  = 8'(T_RDH - 1);

  burst_state_t state;
  bus_drive_t   drv;
  logic [7:0]   tmr;
  logic [7:0]   hw_left;
  logic [23:0]  addr_q;

  // Each transition loads the pin drive of the state being entered, so the
  // pins change on the same edge as the state register.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state   <= S_IDLE;
      drv     <= drive_for(S_IDLE, 24'h0);
      tmr     <= 8'd0;
      hw_left <= 8'd0;
      addr_q  <= 24'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q  <= addr;
            hw_left <= len;
            if (len == 8'd0) begin
              state <= S_END;
              drv   <= drive_for(S_END, addr);
            end else begin
              state <= S_ADDR_SETUP;
              drv   <= drive_for(S_ADDR_SETUP, addr);
              tmr   <= AS_LD;
            end
          end
        end
        S_ADDR_SETUP: begin
          if (tmr == 8'd0) begin
            state <= S_ADDR_HOLD;
            drv   <= drive_for(S_ADDR_HOLD, addr_q);
            tmr   <= AH_LD;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_ADDR_HOLD: begin
          if (tmr == 8'd0) begin
            state <= S_TURN;
            drv   <= drive_for(S_TURN, addr_q);
            tmr   <= TURN_LD;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_TURN: begin
          if (tmr == 8'd0) begin
            state <= S_RD_LOW;
            drv   <= drive_for(S_RD_LOW, addr_q);
            tmr   <= RD_LD;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_RD_LOW: begin
          if (tmr == 8'd0) begin
            state   <= S_RD_HIGH;
            drv     <= drive_for(S_RD_HIGH, addr_q);
            tmr     <= RDH_LD;
            hw_left <= hw_left - 8'd1;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_RD_HIGH: begin
          if (tmr == 8'd0) begin
            if (hw_left != 8'd0) begin
              state <= S_RD_LOW;
              drv   <= drive_for(S_RD_LOW, addr_q);
              tmr   <= RD_LD;
            end else begin
              state <= S_END;
              drv   <= drive_for(S_END, addr_q);
            end
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_END: begin
          state <= S_IDLE;
          drv   <= drive_for(S_IDLE, addr_q);
        end
        default: begin
          state <= S_IDLE;
          drv   <= drive_for(S_IDLE, addr_q);
        end
      endcase
    end
  end

  assign cs_n   = drv.cs_n;
  assign rd_n   = drv.rd_n;
  assign ad_oe  = drv.ad_oe;
  assign ad_out = drv.ad_out;
  assign a_hi   = drv.a_hi;
  assign busy   = drv.busy;
  assign done   = drv.done;
  assign sample = (state == S_RD_LOW) && (tmr == 8'd0);

endmodule

// File: rtl/gba_cart_reader.sv
// gba_cart_reader
// Reads a burst of halfwords from a GBA cart over the Pocket cartridge port
// and classifies rumble carts from the header game code.
//   clk_74a, reset      : clock, synchronous active-high reset
//   start, addr, len    : burst request
//   rd_data, rd_valid   : sampled halfword and its one-cycle strobe
//   busy, done          : burst status
//   rumble_cart         : game code character 0 is "R" or "V"
//   cart_tran_bank0     : [7]=z, [6]=/WR, [5]=/RD, [4]=/CS
//   cart_tran_bank1     : A[23:16]
//   cart_tran_bank2/3   : AD[15:8] / AD[7:0] (bidirectional)
//   cart_tran_bank*_dir : 1 = drive, 0 = input
module gba_cart_reader
  import gba_cart_pkg::*;
#(
  parameter int T_AS   = 4,
  parameter int T_AH   = 4,
  parameter int T_TURN = 2,
  parameter int T_RD   = 12,
  parameter int T_RDH  = 4
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        rumble_cart,
  output wire  [7:4]  cart_tran_bank0,
  output logic [7:0]  cart_tran_bank1,
  inout  wire  [7:0]  cart_tran_bank2,
  inout  wire  [7:0]  cart_tran_bank3,
  output logic        cart_tran_bank0_dir,
  output logic        cart_tran_bank1_dir,
  output logic        cart_tran_bank2_dir,
  output logic        cart_tran_bank3_dir
);

  logic        cs_n;
  logic        rd_n;
  logic        ad_oe;
  logic [15:0] ad_out;
  logic [7:0]  a_hi;
  logic        sample;
  logic [15:0] ad_in;

  logic        hdr_burst;
  logic        first_pending;
  logic        char_ok;
  logic [7:0]  code_char;

  gba_rom_burst #(
    .T_AS   (T_AS),
    .T_AH   (T_AH),
    .T_TURN (T_TURN),
    .T_RD   (T_RD),
    .T_RDH  (T_RDH)
  ) u_burst (
    .clk_74a (clk_74a),
    .reset   (reset),
    .start   (start),
    .addr    (addr),
    .len     (len),
    .cs_n    (cs_n),
    .rd_n    (rd_n),
    .ad_oe   (ad_oe),
    .ad_out  (ad_out),
    .a_hi    (a_hi),
    .busy    (busy),
    .done    (done),
    .sample  (sample)
  );

  assign cart_tran_bank0[7]        = 1'bz;
  assign cart_tran_bank0[WR_N_BIT] = 1'b1;
  assign cart_tran_bank0[RD_N_BIT] = rd_n;
  assign cart_tran_bank0[CS_N_BIT] = cs_n;
  assign cart_tran_bank1           = a_hi;
  assign cart_tran_bank2           = ad_oe ? ad_out[15:8] : 8'hzz;
  assign cart_tran_bank3           = ad_oe ? ad_out[7:0]  : 8'hzz;
  assign cart_tran_bank0_dir       = 1'b1;
  assign cart_tran_bank1_dir       = 1'b1;
  assign cart_tran_bank2_dir       = ad_oe;
  assign cart_tran_bank3_dir       = ad_oe;

  // Sampled without a synchronizer: the cart has held AD stable for T_RD cycles.
  assign ad_in = {cart_tran_bank2, cart_tran_bank3};

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      rd_data       <= 16'h0000;
      rd_valid      <= 1'b0;
      rumble_cart   <= 1'b0;
      hdr_burst     <= 1'b0;
      first_pending <= 1'b0;
      char_ok       <= 1'b0;
      code_char     <= 8'h00;
    end else begin
      rd_valid <= sample;
      if (sample) rd_data <= ad_in;

      if (start && !busy) begin
        hdr_burst     <= (addr == GAME_CODE_HW_ADDR);
        first_pending <= 1'b1;
        char_ok       <= 1'b0;
      end else if (sample && first_pending) begin
        first_pending <= 1'b0;
        code_char     <= ad_in[7:0];
        char_ok       <= 1'b1;
      end

      // A zero-length header burst captured nothing, so it leaves the flag alone.
      if (done && hdr_burst && char_ok) rumble_cart <= is_rumble_code(code_char);
    end
  end

endmodule
